// File: rtl/nvram_pkg.sv
// Shared state encodings and constants for the NVRAM upload reader.
// Optional dirty tracking is enabled with the DIRTY_TRACK_EN macro.
package nvram_pkg;

  localparam logic [2:0] IDLE     = 3'd0;
  localparam logic [2:0] PAUSE    = 3'd1;
  localparam logic [2:0] READY    = 3'd2;
  localparam logic [2:0] FETCH    = 3'd3;
  localparam logic [2:0] WAIT_ACK = 3'd4;

  localparam logic [7:0] OOW_FILL         = 8'hFF;
  localparam logic [7:0] DEF_UPLOAD_INDEX = 8'd4;

  // True when any address bit at or above the window width is set.
  function automatic logic out_of_window(input logic [24:0] addr, input int aw);
    logic hit;
    hit = 1'b0;
    for (int i = 0; i < 25; i++)
      if (i >= aw && addr[i]) hit = 1'b1;
    return hit;
  endfunction

endpackage

// File: rtl/nvram_dirty_tracker.sv
// Watches game CPU writes into the window and requests an upload once the
// writes have settled for DIRTY_VBL_WAIT vblank edges (DIRTY_TRACK_EN builds).
module nvram_dirty_tracker
  import nvram_pkg::*;
#(
  parameter int DIRTY_VBL_WAIT = 2
) (
  input  logic clk_sys,
  input  logic reset,
  input  logic cpu_wr,
  input  logic cpu_in_win,
  input  logic vblank,
  input  logic idle,
  output logic upload_req
);

  logic       dirty_reg, vbl_prev_reg, req_reg;
  logic [7:0] cnt_reg, cnt_next;
  logic       wr_hit, vbl_rise, fire;

  always_comb begin
    wr_hit   = cpu_wr & cpu_in_win;
    vbl_rise = vblank & ~vbl_prev_reg;
    cnt_next = cnt_reg;
    if (dirty_reg && vbl_rise && (cnt_reg < 8'(DIRTY_VBL_WAIT)))
      cnt_next = cnt_reg + 8'd1;
    // Counter saturates while an upload is running, so the request fires once idle.
    fire = dirty_reg && idle && (cnt_next >= 8'(DIRTY_VBL_WAIT));
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      dirty_reg    <= 1'b0;
      vbl_prev_reg <= 1'b0;
      req_reg      <= 1'b0;
      cnt_reg      <= 8'd0;
    end else begin
      vbl_prev_reg <= vblank;
      req_reg      <= fire;
      if (wr_hit) begin
        dirty_reg <= 1'b1;
        cnt_reg   <= 8'd0;
      end else if (fire) begin
        dirty_reg <= 1'b0;
        cnt_reg   <= 8'd0;
      end else begin
        cnt_reg <= cnt_next;
      end
    end
  end

  assign upload_req = req_reg;

endmodule

// File: rtl/nvram_upload_reader.sv
// Answers HPS upload reads from a request/ack byte memory window while holding
// the game CPU paused. Define DIRTY_TRACK_EN to enable automatic upload requests.
module nvram_upload_reader
  import nvram_pkg::*;
#(
  parameter logic [7:0] UPLOAD_INDEX   = DEF_UPLOAD_INDEX,
  parameter int         WIN_AW         = 10,
  parameter int         PAUSE_CYCLES   = 16,
  parameter int         DIRTY_VBL_WAIT = 2
) (
  input  logic              clk_sys,
  input  logic              reset,
  input  logic              ioctl_upload,
  input  logic [7:0]        ioctl_index,
  input  logic [24:0]       ioctl_addr,
  input  logic              ioctl_rd,
  output logic [7:0]        ioctl_din,
  output logic              ioctl_wait,
  output logic              cpu_pause,
  output logic [WIN_AW-1:0] mem_addr,
  output logic              mem_req,
  input  logic              mem_ack,
  input  logic [7:0]        mem_q,
  input  logic              cpu_wr,
  input  logic              cpu_in_win,
  input  logic              vblank,
  output logic              ioctl_upload_req
);

  localparam int CW = $clog2(PAUSE_CYCLES + 1);

  logic [2:0]        state_reg;
  logic [CW-1:0]     cnt_reg;
  logic              rd_pend_reg;
  logic [24:0]       addr_reg;
  logic [7:0]        din_reg;
  logic              wait_reg, pause_reg, req_reg;
  logic [WIN_AW-1:0] mem_addr_reg;
  logic              active;

  assign active = ioctl_upload && (ioctl_index == UPLOAD_INDEX);

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_reg    <= IDLE;
      cnt_reg      <= '0;
      rd_pend_reg  <= 1'b0;
      addr_reg     <= '0;
      din_reg      <= 8'd0;
      wait_reg     <= 1'b0;
      pause_reg    <= 1'b0;
      req_reg      <= 1'b0;
      mem_addr_reg <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (active) begin
            pause_reg   <= 1'b1;
            cnt_reg     <= CW'(PAUSE_CYCLES - 1);
            rd_pend_reg <= 1'b0;
            state_reg   <= PAUSE;
          end
        end
        PAUSE: begin
          if (!active) begin
            state_reg   <= IDLE;
            pause_reg   <= 1'b0;
            wait_reg    <= 1'b0;
            rd_pend_reg <= 1'b0;
          end else begin
            // A strobe during the pause is held off until the CPU is surely halted.
            if (ioctl_rd) begin
              rd_pend_reg <= 1'b1;
              addr_reg    <= ioctl_addr;
              wait_reg    <= 1'b1;
            end
            if (cnt_reg == '0) begin
              state_reg   <= (rd_pend_reg || ioctl_rd) ? FETCH : READY;
              rd_pend_reg <= 1'b0;
            end else begin
              cnt_reg <= cnt_reg - 1'b1;
            end
          end
        end
        READY: begin
          if (!active) begin
            state_reg <= IDLE;
            pause_reg <= 1'b0;
          end else if (ioctl_rd) begin
            addr_reg  <= ioctl_addr;
            wait_reg  <= 1'b1;
            state_reg <= FETCH;
          end
        end
        FETCH: begin
          if (out_of_window(addr_reg, WIN_AW)) begin
            din_reg   <= OOW_FILL;
            wait_reg  <= 1'b0;
            state_reg <= active ? READY : IDLE;
            if (!active) pause_reg <= 1'b0;
          end else begin
            mem_addr_reg <= addr_reg[WIN_AW-1:0];
            req_reg      <= 1'b1;
            wait_reg     <= 1'b1;
            state_reg    <= WAIT_ACK;
          end
        end
        WAIT_ACK: begin
          // Request is never abandoned here; an abort only takes effect after the ack.
          if (mem_ack) begin
            din_reg   <= mem_q;
            req_reg   <= 1'b0;
            wait_reg  <= 1'b0;
            state_reg <= active ? READY : IDLE;
            if (!active) pause_reg <= 1'b0;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign ioctl_din  = din_reg;
  assign ioctl_wait = wait_reg;
  assign cpu_pause  = pause_reg;
  assign mem_addr   = mem_addr_reg;
  assign mem_req    = req_reg;

`ifdef DIRTY_TRACK_EN
  nvram_dirty_tracker #(
    .DIRTY_VBL_WAIT(DIRTY_VBL_WAIT)
  ) u_dirty (
    .clk_sys   (clk_sys),
    .reset     (reset),
    .cpu_wr    (cpu_wr),
    .cpu_in_win(cpu_in_win),
    .vblank    (vblank),
    .idle      (state_reg == IDLE),
    .upload_req(ioctl_upload_req)
  );
`else
  logic unused_dirty;
  assign unused_dirty     = ^{cpu_wr, cpu_in_win, vblank, DIRTY_VBL_WAIT[0]};
  assign ioctl_upload_req = 1'b0;
`endif

endmodule

// File: tb/tb_nvram_upload_reader.sv
// Directed bench for nvram_upload_reader with a request/ack memory model
// answering ACK_DELAY cycles after the request is seen.
module tb_nvram_upload_reader;

  localparam int ACK_DELAY = 3;
  localparam int HI_MEM    = 2 + ACK_DELAY;
`ifdef DIRTY_TRACK_EN
  localparam logic EXP_PULSE = 1'b1;
`else
  localparam logic EXP_PULSE = 1'b0;
`endif

  logic        clk_sys = 1'b0;
  logic        reset = 1'b1;
  logic        ioctl_upload = 1'b0;
  logic [7:0]  ioctl_index = 8'd0;
  logic [24:0] ioctl_addr = 25'd0;
  logic        ioctl_rd = 1'b0;
  logic [7:0]  ioctl_din;
  logic        ioctl_wait, cpu_pause, mem_req, ioctl_upload_req;
  logic [9:0]  mem_addr;
  logic        mem_ack = 1'b0;
  logic [7:0]  mem_q = 8'd0;
  logic        cpu_wr = 1'b0, cpu_in_win = 1'b0, vblank = 1'b0;

  logic [7:0] mem [0:1023];
  int checks = 0, passes = 0, fails = 0;
  int dly = 0, req_cnt = 0;

  always #5 clk_sys = ~clk_sys;

  nvram_upload_reader dut (
    .clk_sys(clk_sys), .reset(reset), .ioctl_upload(ioctl_upload),
    .ioctl_index(ioctl_index), .ioctl_addr(ioctl_addr), .ioctl_rd(ioctl_rd),
    .ioctl_din(ioctl_din), .ioctl_wait(ioctl_wait), .cpu_pause(cpu_pause),
    .mem_addr(mem_addr), .mem_req(mem_req), .mem_ack(mem_ack), .mem_q(mem_q),
    .cpu_wr(cpu_wr), .cpu_in_win(cpu_in_win), .vblank(vblank),
    .ioctl_upload_req(ioctl_upload_req)
  );

  always @(posedge clk_sys) begin
    if (reset) begin
      mem_ack <= 1'b0;
      dly     <= 0;
    end else if (mem_req && !mem_ack) begin
      if (dly == ACK_DELAY - 1) begin
        mem_ack <= 1'b1;
        mem_q   <= mem[mem_addr];
        dly     <= 0;
      end else begin
        dly <= dly + 1;
      end
    end else begin
      mem_ack <= 1'b0;
    end
    if (ioctl_upload_req) req_cnt <= req_cnt + 1;
  end

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic read_byte(input string tag, input logic [24:0] addr,
                           input logic [7:0] exp_din, input int exp_hi);
    int   hi;
    logic seen_req;
    ioctl_addr = addr;
    ioctl_rd   = 1'b1;
    tick();
    ioctl_rd = 1'b0;
    hi       = 0;
    seen_req = 1'b0;
    for (int i = 0; i < 50 && ioctl_wait; i++) begin
      hi++;
      seen_req |= mem_req;
      tick();
    end
    check({tag, " wait_cycles"}, 32'(hi), 32'(exp_hi));
    check({tag, " din"}, 32'(ioctl_din), 32'(exp_din));
    check({tag, " req_seen"}, 32'(seen_req), 32'(exp_hi > 1));
    check({tag, " req_idle"}, 32'(mem_req), 32'd0);
    check({tag, " pause"}, 32'(cpu_pause), 32'd1);
  endtask

  task automatic vbl_pulse();
    vblank = 1'b1;
    tick();
    vblank = 1'b0;
    tick();
  endtask

  initial begin
    int   n;
    logic bad;
    for (int i = 0; i < 1024; i++) mem[i] = 8'h00;
    mem[0] = 8'h11; mem[1] = 8'h22; mem[2] = 8'h33; mem[3] = 8'h44; mem[5] = 8'h5A;

    repeat (3) tick();
    check("rst din", 32'(ioctl_din), 32'd0);
    check("rst wait", 32'(ioctl_wait), 32'd0);
    check("rst pause", 32'(cpu_pause), 32'd0);
    check("rst req", 32'(mem_req), 32'd0);
    check("rst addr", 32'(mem_addr), 32'd0);
    check("rst upreq", 32'(ioctl_upload_req), 32'd0);
    reset = 1'b0;
    tick();

    // Early strobe during the pause window
    ioctl_index  = 8'd4;
    ioctl_upload = 1'b1;
    tick();
    check("early pause", 32'(cpu_pause), 32'd1);
    check("early wait_pre", 32'(ioctl_wait), 32'd0);
    ioctl_addr = 25'd5;
    ioctl_rd   = 1'b1;
    tick();
    ioctl_rd = 1'b0;
    check("early wait", 32'(ioctl_wait), 32'd1);
    n   = 0;
    bad = 1'b0;
    for (int i = 0; i < 40 && !mem_req; i++) begin
      if (!ioctl_wait) bad = 1'b1;
      n++;
      tick();
    end
    check("early req_delay", 32'(n), 32'd16);
    check("early wait_held", 32'(bad), 32'd0);
    for (int i = 0; i < 50 && ioctl_wait; i++) tick();
    check("early din", 32'(ioctl_din), 32'h5A);

    read_byte("rd0", 25'd0, 8'h11, HI_MEM);
    read_byte("rd1", 25'd1, 8'h22, HI_MEM);
    read_byte("rd2", 25'd2, 8'h33, HI_MEM);
    read_byte("rd3", 25'd3, 8'h44, HI_MEM);

    read_byte("oow", 25'h400, 8'hFF, 1);
    repeat (3) tick();
    check("oow din_stable", 32'(ioctl_din), 32'hFF);

    // Second strobe while the first fetch is outstanding is ignored
    ioctl_addr = 25'd1;
    ioctl_rd   = 1'b1;
    tick();
    ioctl_rd = 1'b0;
    tick();
    ioctl_addr = 25'd2;
    ioctl_rd   = 1'b1;
    tick();
    ioctl_rd = 1'b0;
    check("viol wait", 32'(ioctl_wait), 32'd1);
    for (int i = 0; i < 50 && ioctl_wait; i++) tick();
    check("viol din", 32'(ioctl_din), 32'h22);
    read_byte("viol next", 25'd3, 8'h44, HI_MEM);

    // Abort while waiting for the ack
    ioctl_addr = 25'd2;
    ioctl_rd   = 1'b1;
    tick();
    ioctl_rd = 1'b0;
    tick();
    tick();
    ioctl_upload = 1'b0;
    tick();
    check("abort req_held", 32'(mem_req), 32'd1);
    check("abort pause_held", 32'(cpu_pause), 32'd1);
    for (int i = 0; i < 50 && mem_req; i++) tick();
    check("abort pause", 32'(cpu_pause), 32'd0);
    check("abort din", 32'(ioctl_din), 32'h33);
    check("abort wait", 32'(ioctl_wait), 32'd0);

    // Abort from READY
    ioctl_upload = 1'b1;
    repeat (20) tick();
    check("ready pause", 32'(cpu_pause), 32'd1);
    ioctl_upload = 1'b0;
    tick();
    check("ready abort pause", 32'(cpu_pause), 32'd0);

    // Reset while a fetch is outstanding
    ioctl_upload = 1'b1;
    repeat (20) tick();
    ioctl_addr = 25'd0;
    ioctl_rd   = 1'b1;
    tick();
    ioctl_rd = 1'b0;
    tick();
    tick();
    check("mid req", 32'(mem_req), 32'd1);
    reset        = 1'b1;
    ioctl_upload = 1'b0;
    tick();
    check("mid rst req", 32'(mem_req), 32'd0);
    check("mid rst wait", 32'(ioctl_wait), 32'd0);
    check("mid rst pause", 32'(cpu_pause), 32'd0);
    check("mid rst din", 32'(ioctl_din), 32'd0);
    reset = 1'b0;
    tick();

    // Upload for another index must be ignored
    ioctl_index  = 8'd0;
    ioctl_upload = 1'b1;
    bad          = 1'b0;
    for (int i = 0; i < 20; i++) begin
      ioctl_addr = 25'd1;
      ioctl_rd   = (i % 4 == 1);
      tick();
      if (cpu_pause || mem_req || ioctl_wait) bad = 1'b1;
    end
    ioctl_rd = 1'b0;
    check("idx inactive", 32'(bad), 32'd0);
    check("idx din", 32'(ioctl_din), 32'd0);
    ioctl_upload = 1'b0;
    ioctl_index  = 8'd4;
    tick();

    // Dirty tracking: writes outside the window and bare vblanks do nothing
    cpu_wr     = 1'b1;
    cpu_in_win = 1'b0;
    tick();
    cpu_wr = 1'b0;
    repeat (3) vbl_pulse();
    check("dirty none", 32'(req_cnt), 32'd0);
    cpu_wr     = 1'b1;
    cpu_in_win = 1'b1;
    tick();
    cpu_wr     = 1'b0;
    cpu_in_win = 1'b0;
    vblank     = 1'b1;
    tick();
    check("dirty edge1", 32'(ioctl_upload_req), 32'd0);
    vblank = 1'b0;
    tick();
    vblank = 1'b1;
    tick();
    check("dirty edge2", 32'(ioctl_upload_req), 32'(EXP_PULSE));
    vblank = 1'b0;
    tick();
    check("dirty pulse_end", 32'(ioctl_upload_req), 32'd0);
    repeat (2) vbl_pulse();
    check("dirty count", 32'(req_cnt), 32'(EXP_PULSE));

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/nvram_upload_reader.md
Name: nvram_upload_reader

Overview:
- Serves HPS upload requests (save hiscore/NVRAM to SD) by reading bytes from a core-side memory window and returning them on the ioctl upload bus.
- It is the read-back counterpart of the ROM download write path.
- Sits between hps_io (ioctl_upload/ioctl_rd/ioctl_din/ioctl_wait) and a request/ack byte memory port, typically a dual-port hiscore RAM.
- Holds the game CPU paused for the duration of the upload.

Parameters:
- UPLOAD_INDEX, 8'd4, ioctl_index value this block answers.
- WIN_AW, 10, address width of memory window; window size is 2^WIN_AW bytes.
- PAUSE_CYCLES, 16, cycles cpu_pause must be held before the first memory fetch.
- DIRTY_VBL_WAIT, 2, vblank rising edges between last dirty write and the upload request (DIRTY_TRACK_EN only).

Ports:
- clk_sys  in  1  system clock; all logic is on its rising edge.
- reset  in  1  synchronous, active-high.
- ioctl_upload  in  1  HPS upload in progress.
- ioctl_index  in  8  selected upload index.
- ioctl_addr  in  25  byte address requested by HPS.
- ioctl_rd  in  1  one-cycle read strobe for ioctl_addr.
- ioctl_din  out  8  byte returned to HPS.
- ioctl_wait  out  1  stalls HPS while a fetch is outstanding.
- cpu_pause  out  1  halts game CPU.
- mem_addr  out  WIN_AW  memory read address.
- mem_req  out  1  read request, level held until ack.
- mem_ack  in  1  one-cycle ack; mem_q valid the same cycle.
- mem_q  in  8  read data.
- cpu_wr  in  1  game CPU write strobe (DIRTY_TRACK_EN only).
- cpu_in_win  in  1  cpu_wr targets the window (DIRTY_TRACK_EN only).
- vblank  in  1  video vblank (DIRTY_TRACK_EN only).
- ioctl_upload_req  out  1  one-cycle request to HPS to start an upload.

Behaviour:
- Reset values: ioctl_din=0, ioctl_wait=0, cpu_pause=0, mem_req=0, mem_addr=0, ioctl_upload_req=0. State goes to IDLE and the pause counter clears.
- active = ioctl_upload & (ioctl_index==UPLOAD_INDEX).
- FSM states:
  - IDLE: on active, set cpu_pause=1, load counter=PAUSE_CYCLES-1, go to PAUSE.
  - PAUSE: counter decrements each cycle. ioctl_wait=1 while in PAUSE if an ioctl_rd arrived; that strobe is latched. At counter==0 go to READY, or go to FETCH if a strobe is latched.
  - READY: on ioctl_rd, go to FETCH; ioctl_wait asserts the cycle after the strobe.
  - FETCH: mem_addr=latched ioctl_addr[WIN_AW-1:0], mem_req=1, ioctl_wait=1, go to WAIT_ACK.
  - WAIT_ACK: hold mem_req until mem_ack. On ack: ioctl_din<=mem_q, mem_req=0, ioctl_wait=0 next cycle, go to READY.
- Latency: ioctl_rd to ioctl_din valid = 2 + memory ack delay cycles. ioctl_din is stable until the next fetch completes.
- Out-of-window address (ioctl_addr[24:WIN_AW]!=0): no memory access. ioctl_din<=8'hFF and return to READY in 1 cycle, with ioctl_wait pulsed one cycle.
- ioctl_rd arriving while in FETCH/WAIT_ACK: protocol violation. It is ignored, ioctl_wait stays high.
- active falls in any state:
  - from READY/PAUSE: go to IDLE immediately, cpu_pause=0 the next cycle.
  - from FETCH/WAIT_ACK: finish the outstanding ack first, then go to IDLE. mem_req is never dropped before ack.
- reset mid-fetch: all outputs return to reset values next cycle. The memory side must tolerate an abandoned req.
- ioctl_index mismatch: block stays IDLE and all outputs stay inactive.

Optional Feature:
DIRTY_TRACK_EN
- With the macro:
  - cpu_wr & cpu_in_win sets a dirty flag and resets a vblank-edge counter.
  - Each vblank rising edge while dirty increments the counter.
  - When the counter reaches DIRTY_VBL_WAIT and the state is IDLE, ioctl_upload_req pulses for 1 cycle, and dirty and the counter clear.
  - A write on the same cycle as the pulse re-sets dirty.
  - Writes during an upload set dirty, so a further request follows later.
- Without the macro: ioctl_upload_req is tied 0 and cpu_wr/cpu_in_win/vblank are ignored. The ports are still present.

Decomposition:
- Shared package nvram_pkg holds:
  - state enum (IDLE, PAUSE, READY, FETCH, WAIT_ACK);
  - OOW_FILL=8'hFF;
  - default UPLOAD_INDEX.
- One sub-module, nvram_dirty_tracker, holds the DIRTY_TRACK_EN logic: flag, vblank edge detect, counter, request pulse. It is instantiated only under the macro.

Test Plan:
- Basic read: preload mem[0..3]=11,22,33,44; upload index 4; rd at addr 0..3 with ack delay 3 -> ioctl_din=11,22,33,44. ioctl_wait high exactly from rd+1 until ack+1. cpu_pause high throughout.
- Early strobe: rd at addr 5 during PAUSE with PAUSE_CYCLES=16 -> mem_req not before cycle 16. Correct byte returned. ioctl_wait high from the strobe.
- Out of window: WIN_AW=10, rd at addr 0x400 -> no mem_req, ioctl_din=FF, ioctl_wait one-cycle pulse.
- Abort: ioctl_upload drops while in WAIT_ACK -> mem_req held until ack, then IDLE, cpu_pause=0 one cycle later.
- Wrong index: ioctl_index=0 upload with rd strobes -> cpu_pause=0, mem_req=0, ioctl_din unchanged.
- DIRTY_TRACK_EN, DIRTY_VBL_WAIT=2: cpu_wr in window, then 2 vblank edges -> single-cycle ioctl_upload_req on the second edge. No pulse without a write.
